// File: rtl/param_updown_counter.sv
// Purpose: parametrised up/down counter with programmable limit, wrap/saturate, load clamp, tc pulse, sticky ovf.
// Latency: q/tc/ovf update on the command edge; at_max/at_zero follow q combinationally.
// Backpressure: none; every enabled edge is accepted, clr > load > en.
module param_updown_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc,
  output logic             ovf
);

  logic             up_bound;
  logic             dn_bound;
  logic [WIDTH-1:0] load_val;

  // Boundary detection; up uses >= so a runtime-lowered limit still traps q.
  always_comb begin
    up_bound = (q >= limit);
    dn_bound = (q == '0);
    load_val = (data_in > limit) ? limit : data_in;
  end

  assign at_max  = (q == limit);
  assign at_zero = (q == '0);

  // Counter state: exclusive clr > load > en priority, tc flags a boundary hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RESET_VALUE;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      q  <= load_val;
      tc <= 1'b0;
    end else if (en) begin
      if (up_dn) begin
        if (up_bound) begin
          tc <= 1'b1;
          if (!sat_mode) begin
            q   <= '0;
            ovf <= 1'b1;
          end
        end else begin
          q  <= q + 1'b1;
          tc <= 1'b0;
        end
      end else begin
        if (dn_bound) begin
          tc <= 1'b1;
          if (!sat_mode) begin
            q   <= limit;
            ovf <= 1'b1;
          end
        end else begin
          q  <= q - 1'b1;
          tc <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
